// File: rtl/imem_program_loader.sv
// imem_program_loader: packs a byte stream into 16-bit words, writes them to instruction memory, then releases the core
module imem_program_loader #(
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8,
  parameter int INST_W = 2 * BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, FINISH, RUN, ERR} state_t;
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  state_t state;
  logic [BYTE_W-1:0] hi;
  logic hs;
  assign hs = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hi         <= '0;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE: begin
          state    <= LOAD_HI;
          in_ready <= 1'b1;
        end
        LOAD_HI: if (hs) begin
          // a last flag on a high byte means an odd or empty program
          if (in_last || word_count == CAP) begin
            state    <= ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            hi    <= in_data;
            state <= LOAD_LO;
          end
        end
        LOAD_LO: if (hs) begin
          im_we      <= 1'b1;
          im_addr    <= word_count[ADDR_W-1:0];
          im_wdata   <= {hi, in_data};
          word_count <= word_count + (ADDR_W+1)'(1);
          state      <= in_last ? FINISH : LOAD_HI;
          in_ready   <= !in_last;
        end
        FINISH: begin
          state      <= RUN;
          core_reset <= 1'b0;
          load_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed self-checking bench for the instruction memory loader
module tb_imem_program_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, im_we, core_reset, load_done, err;
  logic [4:0]  im_addr;
  logic [15:0] im_wdata;
  logic [5:0]  word_count;
  int tests = 0;
  int fails = 0;
  int nw = 0;
  logic [4:0]  wr_addr [64];
  logic [15:0] wr_data [64];

  imem_program_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_reset(core_reset), .load_done(load_done), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (im_we && nw < 64) begin
    wr_addr[nw] = im_addr;
    wr_data[nw] = im_wdata;
    nw = nw + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready got %0b expected 1 for byte %0h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    @(negedge clk);
    tests += 8;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
    if (im_we !== 1'b0) begin fails++; $display("FAIL rst_im_we: got %0b expected 0", im_we); end
    if (im_addr !== 5'd0) begin fails++; $display("FAIL rst_im_addr: got %0h expected 0", im_addr); end
    if (im_wdata !== 16'h0) begin fails++; $display("FAIL rst_im_wdata: got %0h expected 0", im_wdata); end
    if (core_reset !== 1'b1) begin fails++; $display("FAIL rst_core_reset: got %0b expected 1", core_reset); end
    if (load_done !== 1'b0) begin fails++; $display("FAIL rst_load_done: got %0b expected 0", load_done); end
    if (word_count !== 6'd0) begin fails++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
    if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b expected 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_three_word();
    apply_reset();
    nw = 0;
    send(8'h20, 0); send(8'h05, 0);
    send(8'h20, 0); send(8'h06, 0);
    send(8'h00, 0); send(8'h8A, 1);
    tests += 2;
    if (im_we !== 1'b1) begin fails++; $display("FAIL b2b_we_latency: got %0b expected 1", im_we); end
    if (core_reset !== 1'b1) begin fails++; $display("FAIL b2b_core_reset_early: got %0b expected 1", core_reset); end
    @(negedge clk);
    tests += 5;
    if (core_reset !== 1'b0) begin fails++; $display("FAIL b2b_core_reset: got %0b expected 0", core_reset); end
    if (load_done !== 1'b1) begin fails++; $display("FAIL b2b_load_done: got %0b expected 1", load_done); end
    if (word_count !== 6'd3) begin fails++; $display("FAIL b2b_word_count: got %0d expected 3", word_count); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready: got %0b expected 0", in_ready); end
    if (nw !== 3) begin fails++; $display("FAIL b2b_writes: got %0d expected 3", nw); end
    tests += 3;
    if ({wr_addr[0], wr_data[0]} !== {5'd0, 16'h2005}) begin fails++; $display("FAIL b2b_w0: got %0h/%0h expected 0/2005", wr_addr[0], wr_data[0]); end
    if ({wr_addr[1], wr_data[1]} !== {5'd1, 16'h2006}) begin fails++; $display("FAIL b2b_w1: got %0h/%0h expected 1/2006", wr_addr[1], wr_data[1]); end
    if ({wr_addr[2], wr_data[2]} !== {5'd2, 16'h008A}) begin fails++; $display("FAIL b2b_w2: got %0h/%0h expected 2/008a", wr_addr[2], wr_data[2]); end
  endtask

  task automatic test_stalled();
    logic [7:0] bytes [6];
    bytes = '{8'h20, 8'h05, 8'h20, 8'h06, 8'h00, 8'h8A};
    apply_reset();
    nw = 0;
    for (int w = 0; w < 3; w++) begin
      send(bytes[2*w], 0);
      repeat (2) begin
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_in_ready: got %0b expected 1", in_ready); end
        @(negedge clk);
      end
      send(bytes[2*w+1], w == 2);
    end
    @(negedge clk);
    tests += 5;
    if (load_done !== 1'b1) begin fails++; $display("FAIL stall_load_done: got %0b expected 1", load_done); end
    if (nw !== 3) begin fails++; $display("FAIL stall_writes: got %0d expected 3", nw); end
    if ({wr_addr[0], wr_data[0]} !== {5'd0, 16'h2005}) begin fails++; $display("FAIL stall_w0: got %0h/%0h expected 0/2005", wr_addr[0], wr_data[0]); end
    if ({wr_addr[1], wr_data[1]} !== {5'd1, 16'h2006}) begin fails++; $display("FAIL stall_w1: got %0h/%0h expected 1/2006", wr_addr[1], wr_data[1]); end
    if ({wr_addr[2], wr_data[2]} !== {5'd2, 16'h008A}) begin fails++; $display("FAIL stall_w2: got %0h/%0h expected 2/008a", wr_addr[2], wr_data[2]); end
  endtask

  task automatic test_odd_length();
    apply_reset();
    nw = 0;
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 1);
    repeat (2) @(negedge clk);
    tests += 6;
    if (nw !== 1) begin fails++; $display("FAIL odd_writes: got %0d expected 1", nw); end
    if (wr_data[0] !== 16'h1234) begin fails++; $display("FAIL odd_w0: got %0h expected 1234", wr_data[0]); end
    if (err !== 1'b1) begin fails++; $display("FAIL odd_err: got %0b expected 1", err); end
    if (core_reset !== 1'b1) begin fails++; $display("FAIL odd_core_reset: got %0b expected 1", core_reset); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL odd_in_ready: got %0b expected 0", in_ready); end
    if (load_done !== 1'b0) begin fails++; $display("FAIL odd_load_done: got %0b expected 0", load_done); end
  endtask

  task automatic test_capacity();
    apply_reset();
    nw = 0;
    for (int i = 0; i < 32; i++) begin
      send(8'(i), 0);
      send(8'h80 | 8'(i), i == 31);
    end
    @(negedge clk);
    tests += 4;
    if (load_done !== 1'b1) begin fails++; $display("FAIL cap_load_done: got %0b expected 1", load_done); end
    if (word_count !== 6'd32) begin fails++; $display("FAIL cap_word_count: got %0d expected 32", word_count); end
    if (err !== 1'b0) begin fails++; $display("FAIL cap_err: got %0b expected 0", err); end
    if (nw !== 32) begin fails++; $display("FAIL cap_writes: got %0d expected 32", nw); end
    for (int i = 0; i < 32; i++) begin
      tests++;
      if ({wr_addr[i], wr_data[i]} !== {5'(i), 8'(i), 8'h80 | 8'(i)}) begin
        fails++;
        $display("FAIL cap_w%0d: got %0h/%0h expected %0h/%0h", i, wr_addr[i], wr_data[i], i, {8'(i), 8'h80 | 8'(i)});
      end
    end
    apply_reset();
    nw = 0;
    for (int i = 0; i < 32; i++) begin
      send(8'(i), 0);
      send(8'h40, 0);
    end
    send(8'hEE, 0);
    repeat (2) @(negedge clk);
    tests += 5;
    if (err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %0b expected 1", err); end
    if (nw !== 32) begin fails++; $display("FAIL ovf_writes: got %0d expected 32", nw); end
    if (word_count !== 6'd32) begin fails++; $display("FAIL ovf_word_count: got %0d expected 32", word_count); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready: got %0b expected 0", in_ready); end
    if (core_reset !== 1'b1) begin fails++; $display("FAIL ovf_core_reset: got %0b expected 1", core_reset); end
  endtask

  task automatic test_reset_midload();
    apply_reset();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    reset = 1'b1;
    @(negedge clk);
    tests += 5;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %0b expected 0", in_ready); end
    if (word_count !== 6'd0) begin fails++; $display("FAIL mid_word_count: got %0d expected 0", word_count); end
    if (core_reset !== 1'b1) begin fails++; $display("FAIL mid_core_reset: got %0b expected 1", core_reset); end
    if (im_addr !== 5'd0) begin fails++; $display("FAIL mid_im_addr: got %0h expected 0", im_addr); end
    if (im_wdata !== 16'h0) begin fails++; $display("FAIL mid_im_wdata: got %0h expected 0", im_wdata); end
    reset = 1'b0;
    nw = 0;
    send(8'hAB, 0); send(8'hCD, 1);
    @(negedge clk);
    tests += 4;
    if (nw !== 1) begin fails++; $display("FAIL mid_writes: got %0d expected 1", nw); end
    if ({wr_addr[0], wr_data[0]} !== {5'd0, 16'hABCD}) begin fails++; $display("FAIL mid_w0: got %0h/%0h expected 0/abcd", wr_addr[0], wr_data[0]); end
    if (load_done !== 1'b1) begin fails++; $display("FAIL mid_load_done: got %0b expected 1", load_done); end
    if (word_count !== 6'd1) begin fails++; $display("FAIL mid_word_count_end: got %0d expected 1", word_count); end
  endtask

  task automatic test_reset_in_run();
    reset = 1'b1;
    @(negedge clk);
    tests += 3;
    if (core_reset !== 1'b1) begin fails++; $display("FAIL run_rst_core_reset: got %0b expected 1", core_reset); end
    if (load_done !== 1'b0) begin fails++; $display("FAIL run_rst_load_done: got %0b expected 0", load_done); end
    if (word_count !== 6'd0) begin fails++; $display("FAIL run_rst_word_count: got %0d expected 0", word_count); end
    reset = 1'b0;
    nw = 0;
    send(8'h11, 0); send(8'h22, 1);
    @(negedge clk);
    tests += 3;
    if (nw !== 1) begin fails++; $display("FAIL run_reload_writes: got %0d expected 1", nw); end
    if ({wr_addr[0], wr_data[0]} !== {5'd0, 16'h1122}) begin fails++; $display("FAIL run_reload_w0: got %0h/%0h expected 0/1122", wr_addr[0], wr_data[0]); end
    if (core_reset !== 1'b0) begin fails++; $display("FAIL run_reload_core_reset: got %0b expected 0", core_reset); end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_stalled();
    test_odd_length();
    test_capacity();
    test_reset_midload();
    test_reset_in_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
